load_reg_bank: RTL and testbench

- Parametrised successor to the fixed 16-bit load register, used by the counter/TramelBlaze datapath.
- Provides a WIDTH-bit live register with byte-enabled load, up/down counting with wrap flags, and synchronous clear.
- Adds a double-buffered shadow register: software stages a value, then commits it atomically.
- Sits between the TramelBlaze output-port decode and the counter/display logic.

---
 rtl/tb_regs_pkg.sv | 19 +
 rtl/load_reg_bank_if.sv | 33 +++
 rtl/load_reg_bank_be_merge.sv | 21 ++
 rtl/load_reg_bank.sv | 101 ++++++++++
 tb/tb_load_reg_bank.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/tb_regs_pkg.sv
// Shared definitions for the load/shadow register family: lane sizing and q-path select codes.
package tb_regs_pkg;

    localparam int unsigned BYTE_W = 8;

    function automatic int unsigned nbyte_f(input int unsigned width);
        return width / BYTE_W;
    endfunction

    // q-path select, listed in descending priority.
    typedef enum logic [2:0] {
        SEL_CLR,
        SEL_COMMIT,
        SEL_LOAD,
        SEL_CNT,
        SEL_HOLD
    } q_sel_e;

endpackage

// File: rtl/load_reg_bank_if.sv
// Command/status bundle between the output-port decode (master) and load_reg_bank (slave).
interface load_reg_bank_if
    import tb_regs_pkg::*;
#(
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned NBYTE = nbyte_f(WIDTH);

    logic             clr;
    logic             load;
    logic             stage;
    logic             commit;
    logic [NBYTE-1:0] be;
    logic [WIDTH-1:0] d;
    logic             inc;
    logic             dec;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_shadow;
    logic             pend;
    logic             ovf;
    logic             unf;

    modport master (
        output clr, load, stage, commit, be, d, inc, dec,
        input  q, q_shadow, pend, ovf, unf
    );

    modport slave (
        input  clr, load, stage, commit, be, d, inc, dec,
        output q, q_shadow, pend, ovf, unf
    );

endinterface

// File: rtl/load_reg_bank_be_merge.sv
// Byte-lane merge: lanes with be set take new_i, the rest keep old_i.
module be_merge
    import tb_regs_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NBYTE = nbyte_f(WIDTH)
) (
    input  logic [WIDTH-1:0] old_i,
    input  logic [WIDTH-1:0] new_i,
    input  logic [NBYTE-1:0] be_i,
    output logic [WIDTH-1:0] merged_o
);

    always_comb begin
        merged_o = old_i;
        for (int i = 0; i < NBYTE; i++) begin
            if (be_i[i]) merged_o[i*BYTE_W +: BYTE_W] = new_i[i*BYTE_W +: BYTE_W];
        end
    end

endmodule

// File: rtl/load_reg_bank.sv
// Live register with byte-enabled load, wrap-flagged up/down count, and a staged shadow that
// commits atomically into the live register.
module load_reg_bank
    import tb_regs_pkg::*;
#(
    parameter int unsigned    WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    load_reg_bank_if.slave bus
);

    localparam int unsigned NBYTE = nbyte_f(WIDTH);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [WIDTH-1:0] stage_merged;
    logic [WIDTH-1:0] load_merged;
    logic [WIDTH-1:0] shadow_fwd;
    q_sel_e           sel;

    be_merge #(.WIDTH(WIDTH), .NBYTE(NBYTE)) u_stage_merge (
        .old_i    (sh_q),
        .new_i    (bus.d),
        .be_i     (bus.be),
        .merged_o (stage_merged)
    );

    be_merge #(.WIDTH(WIDTH), .NBYTE(NBYTE)) u_load_merge (
        .old_i    (q_q),
        .new_i    (bus.d),
        .be_i     (bus.be),
        .merged_o (load_merged)
    );

    // Same-cycle stage+commit forwards the freshly merged data into q.
    assign shadow_fwd = bus.stage ? stage_merged : sh_q;

    always_comb begin
        sel = SEL_HOLD;
        if (bus.clr)                  sel = SEL_CLR;
        else if (bus.commit)          sel = SEL_COMMIT;
        else if (bus.load)            sel = SEL_LOAD;
        else if (bus.inc ^ bus.dec)   sel = SEL_CNT;
    end

    always_comb begin
        q_d   = q_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        unique case (sel)
            SEL_CLR:    q_d = RESET_VAL;
            SEL_COMMIT: q_d = shadow_fwd;
            SEL_LOAD:   q_d = load_merged;
            SEL_CNT: begin
                if (bus.inc) begin
                    q_d   = q_q + WIDTH'(1);
                    ovf_d = (q_q == '1);
                end else begin
                    q_d   = q_q - WIDTH'(1);
                    unf_d = (q_q == '0);
                end
            end
            default:    q_d = q_q;
        endcase

        sh_d = bus.clr ? RESET_VAL : shadow_fwd;

        pend_d = pend_q;
        if (bus.clr || bus.commit) pend_d = 1'b0;
        else if (bus.stage)        pend_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q    <= RESET_VAL;
            sh_q   <= RESET_VAL;
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            sh_q   <= sh_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    assign bus.q        = q_q;
    assign bus.q_shadow = sh_q;
    assign bus.pend     = pend_q;
    assign bus.ovf      = ovf_q;
    assign bus.unf      = unf_q;

endmodule

// File: tb/tb_load_reg_bank.sv
// Scoreboard bench: drives a 16-bit and a 32-bit instance with identical commands and checks
// both against a lane/arithmetic reference model.
module tb_load_reg_bank;
    import tb_regs_pkg::*;

    localparam logic [31:0] RV16 = 32'h0000_00A5;
    localparam logic [31:0] RV32 = 32'hDEAD_0001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        clr, load, stage, commit, inc, dec;
    logic [3:0]  be;
    logic [31:0] d;

    load_reg_bank_if #(.WIDTH(16)) b16 ();
    load_reg_bank_if #(.WIDTH(32)) b32 ();

    assign b16.clr = clr;     assign b32.clr = clr;
    assign b16.load = load;   assign b32.load = load;
    assign b16.stage = stage; assign b32.stage = stage;
    assign b16.commit = commit; assign b32.commit = commit;
    assign b16.inc = inc;     assign b32.inc = inc;
    assign b16.dec = dec;     assign b32.dec = dec;
    assign b16.be = be[1:0];  assign b32.be = be;
    assign b16.d = d[15:0];   assign b32.d = d;

    load_reg_bank #(.WIDTH(16), .RESET_VAL(RV16[15:0])) dut16 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (b16)
    );

    load_reg_bank #(.WIDTH(32), .RESET_VAL(RV32)) dut32 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (b32)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] sh;
        logic        pend;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t exp16_q[$];
    exp_t exp32_q[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_q[2];
    logic [31:0] m_sh[2];
    logic        m_pend[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] en, input int nb);
        logic [31:0] r = old_v;
        for (int i = 0; i < nb; i++) if (en[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_q[0] = RV16; m_sh[0] = RV16; m_pend[0] = 1'b0;
        m_q[1] = RV32; m_sh[1] = RV32; m_pend[1] = 1'b0;
    endtask

    // Applies one sampled command to model k of width w.
    task automatic model_step(input int k, input int w, input logic [31:0] rv, output exp_t e);
        logic [31:0] mask;
        logic [31:0] staged;
        int          nb;
        nb     = w / 8;
        mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        staged = stage ? lane_merge(m_sh[k], d, be, nb) : m_sh[k];
        e.ovf  = 1'b0;
        e.unf  = 1'b0;
        if (clr)                m_q[k] = rv;
        else if (commit)        m_q[k] = staged;
        else if (load)          m_q[k] = lane_merge(m_q[k], d, be, nb);
        else if (inc && !dec) begin
            e.ovf  = (m_q[k] == mask);
            m_q[k] = (m_q[k] + 32'd1) & mask;
        end else if (dec && !inc) begin
            e.unf  = (m_q[k] == 32'd0);
            m_q[k] = (m_q[k] - 32'd1) & mask;
        end
        m_sh[k]   = clr ? rv : staged;
        m_pend[k] = (clr || commit) ? 1'b0 : (stage ? 1'b1 : m_pend[k]);
        e.q    = m_q[k];
        e.sh   = m_sh[k];
        e.pend = m_pend[k];
    endtask

    task automatic cmd(input logic c_clr, input logic c_load, input logic c_stage,
                       input logic c_commit, input logic c_inc, input logic c_dec,
                       input logic [3:0] c_be, input logic [31:0] c_d);
        exp_t e;
        @(negedge clk);
        clr = c_clr; load = c_load; stage = c_stage; commit = c_commit;
        inc = c_inc; dec = c_dec; be = c_be; d = c_d;
        @(posedge clk);
        model_step(0, 16, RV16, e); exp16_q.push_back(e);
        model_step(1, 32, RV32, e); exp32_q.push_back(e);
    endtask

    task automatic idle();
        cmd(0, 0, 0, 0, 0, 0, 4'h0, 32'h0);
    endtask

    // Monitor: outputs are always presented; compare one expected entry per edge.
    always @(posedge clk) begin
        exp_t e;
        #2;
        while (exp16_q.size() > 0) begin
            e = exp16_q.pop_front();
            check("q16",    {16'h0, b16.q},        e.q);
            check("sh16",   {16'h0, b16.q_shadow}, e.sh);
            check("pend16", {31'h0, b16.pend},     {31'h0, e.pend});
            check("ovf16",  {31'h0, b16.ovf},      {31'h0, e.ovf});
            check("unf16",  {31'h0, b16.unf},      {31'h0, e.unf});
        end
        while (exp32_q.size() > 0) begin
            e = exp32_q.pop_front();
            check("q32",    b32.q,             e.q);
            check("sh32",   b32.q_shadow,      e.sh);
            check("pend32", {31'h0, b32.pend}, {31'h0, e.pend});
            check("ovf32",  {31'h0, b32.ovf},  {31'h0, e.ovf});
            check("unf32",  {31'h0, b32.unf},  {31'h0, e.unf});
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_q16"},  {16'h0, b16.q},        RV16);
        check({tag, "_sh16"}, {16'h0, b16.q_shadow}, RV16);
        check({tag, "_q32"},  b32.q,                 RV32);
        check({tag, "_sh32"}, b32.q_shadow,          RV32);
        check({tag, "_flags"}, {29'h0, b16.pend | b32.pend, b16.ovf | b32.ovf, b16.unf | b32.unf},
              32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        clr = 0; load = 0; stage = 0; commit = 0; inc = 0; dec = 0; be = 4'h0; d = 32'h0;
        model_reset();

        // Reset held across clock edges.
        repeat (3) @(posedge clk);
        #1 check_reset_state("rst_hold");
        @(negedge clk) rst_n = 1'b1;

        // Asynchronous reset mid-count, sampled before any further edge.
        cmd(0, 1, 0, 0, 0, 0, 4'hF, 32'h0000_0010);
        cmd(0, 0, 0, 0, 1, 0, 4'h0, 32'h0);
        cmd(0, 0, 0, 0, 1, 0, 4'h0, 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_state("rst_async");
        @(negedge clk) rst_n = 1'b1;
        model_reset();

        // Byte-lane load, then load with no lanes enabled.
        cmd(0, 1, 0, 0, 0, 0, 4'hF, 32'h0000_1234);
        cmd(0, 1, 0, 0, 0, 0, 4'b0010, 32'h0000_ABCD);
        cmd(0, 1, 0, 0, 0, 0, 4'b0000, 32'hFFFF_FFFF);

        // Wrap flags, single-cycle pulses, inc+dec hold.
        cmd(0, 1, 0, 0, 0, 0, 4'hF, 32'h0000_FFFF);
        cmd(0, 0, 0, 0, 1, 0, 4'h0, 32'h0);
        idle();
        cmd(0, 0, 0, 0, 0, 1, 4'h0, 32'h0);
        idle();
        cmd(0, 0, 0, 0, 1, 1, 4'h0, 32'h0);
        cmd(0, 1, 0, 0, 0, 0, 4'hF, 32'hFFFF_FFFF);
        cmd(0, 0, 0, 0, 1, 0, 4'h0, 32'h0);
        cmd(0, 0, 0, 0, 0, 1, 4'h0, 32'h0);

        // Stage, then commit beats a same-cycle load.
        cmd(0, 0, 1, 0, 0, 0, 4'b0011, 32'h0000_5555);
        cmd(0, 1, 0, 1, 0, 0, 4'b0011, 32'h0000_0F0F);

        // Same-cycle stage+commit forwards the merged data.
        cmd(0, 0, 1, 0, 0, 0, 4'hF, 32'h0);
        cmd(0, 0, 1, 1, 0, 0, 4'b0001, 32'h0000_77EE);

        // Clear beats everything.
        cmd(0, 0, 1, 0, 0, 0, 4'hF, 32'h1357_9BDF);
        cmd(0, 1, 0, 0, 0, 0, 4'hF, 32'hFFFF_FFFF);
        cmd(1, 1, 0, 1, 1, 0, 4'hF, 32'h2468_ACE0);
        idle();

        // Randomised traffic, biased toward wrap boundaries.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(3))
                0: rd = 32'hFFFF_FFFF;
                1: rd = 32'h0;
                default: rd = $urandom;
            endcase
            cmd(($urandom_range(15) == 0), ($urandom_range(3) == 0), ($urandom_range(3) == 0),
                ($urandom_range(5) == 0), $urandom_range(1) == 1, $urandom_range(1) == 1,
                4'($urandom_range(15)), rd);
        end
        idle();

        @(posedge clk);
        #3;
        n_checks++;
        if (exp16_q.size() != 0 || exp32_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", exp16_q.size() + exp32_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
